stage_sequencer: RTL and testbench



---
 rtl/stage_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer: game-flow controller for the shooter.
// Sequences stages, schedules fly spawns into free slots, tracks lives and score,
// and emits one-cycle command and sound-event pulses. All outputs are registered.
module stage_sequencer #(
   parameter int unsigned FLY_COUNT     = 12,
   parameter int unsigned FLY_BASE      = 4,
   parameter int unsigned SPAWN_GAP     = 30,
   parameter int unsigned INTRO_FRAMES  = 120,
   parameter int unsigned CLEAR_FRAMES  = 90,
   parameter int unsigned INVULN_FRAMES = 60,
   parameter int unsigned LIVES_INIT    = 3,
   parameter int unsigned POINTS        = 10
) (
   input  logic                 i_clk25,
   input  logic                 i_reset,
   input  logic                 i_frame_tick,
   input  logic                 i_start,
   input  logic                 i_stage_rst,
   input  logic                 i_player_hit,
   input  logic [FLY_COUNT-1:0] i_fly_alive,
   input  logic [FLY_COUNT-1:0] i_fly_hit,
   output logic                 o_spawn_valid,
   output logic [3:0]           o_spawn_idx,
   output logic                 o_fly_clear,
   output logic [2:0]           o_state,
   output logic [3:0]           o_stage,
   output logic [1:0]           o_lives,
   output logic [15:0]          o_score,
   output logic                 o_sfx_hit,
   output logic                 o_sfx_stage,
   output logic                 o_sfx_over
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StIntro = 3'd1,
      StSpawn = 3'd2,
      StPlay  = 3'd3,
      StClear = 3'd4,
      StOver  = 3'd5
   } state_t;

   state_t      r_state;
   logic [3:0]  r_stage;
   logic [1:0]  r_lives;
   logic [15:0] r_score;
   logic        r_spawn_valid;
   logic [3:0]  r_spawn_idx;
   logic        r_fly_clear;
   logic        r_sfx_hit;
   logic        r_sfx_stage;
   logic        r_sfx_over;
   logic [15:0] r_frame_cnt;
   logic [15:0] r_inv_cnt;
   logic [4:0]  r_spawned;
   logic        r_spawn_pend;

   logic        w_free_any;
   logic [3:0]  w_free_idx;
   logic [4:0]  w_hit_cnt;
   logic [16:0] w_score_sum;
   logic [15:0] w_score_next;
   logic [5:0]  w_target_raw;
   logic [4:0]  w_target;
   logic        w_active;
   logic        w_hit_ok;
   logic        w_lose_game;
   logic        w_spawn_due;
   logic        w_rst_stage;

   // Lowest-index free slot and number of kills reported this cycle
   always_comb begin
      w_free_any = 1'b0;
      w_free_idx = 4'd0;
      w_hit_cnt  = 5'd0;
      for (int i = int'(FLY_COUNT) - 1; i >= 0; i--) begin
         if (!i_fly_alive[i]) begin
            w_free_any = 1'b1;
            w_free_idx = 4'(i);
         end
         w_hit_cnt = w_hit_cnt + 5'(i_fly_hit[i]);
      end
   end

   assign w_score_sum  = 17'(r_score) + 17'(w_hit_cnt) * 17'(POINTS);
   assign w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
   assign w_target_raw = 6'(FLY_BASE) + 6'(r_stage) - 6'd1;
   assign w_target     = (w_target_raw > 6'(FLY_COUNT)) ? 5'(FLY_COUNT) : w_target_raw[4:0];
   assign w_active     = (r_state == StSpawn) || (r_state == StPlay);
   assign w_hit_ok     = w_active && i_player_hit && (r_inv_cnt == 16'd0);
   assign w_lose_game  = w_hit_ok && (r_lives == 2'd1);
   // A deferred spawn keeps retrying every cycle until a slot frees up
   assign w_spawn_due  = r_spawn_pend || (i_frame_tick && (r_frame_cnt == 16'd0));
   assign w_rst_stage  = i_stage_rst && ((r_state == StIntro) || (r_state == StSpawn) ||
                                         (r_state == StPlay)  || (r_state == StClear));

   // Game-flow FSM with registered outputs, score, lives and invulnerability window
   always_ff @(posedge i_clk25) begin
      if (i_reset) begin
         r_state       <= StIdle;
         r_stage       <= 4'd1;
         r_lives       <= 2'(LIVES_INIT);
         r_score       <= 16'd0;
         r_spawn_valid <= 1'b0;
         r_spawn_idx   <= 4'd0;
         r_fly_clear   <= 1'b0;
         r_sfx_hit     <= 1'b0;
         r_sfx_stage   <= 1'b0;
         r_sfx_over    <= 1'b0;
         r_frame_cnt   <= 16'd0;
         r_inv_cnt     <= 16'd0;
         r_spawned     <= 5'd0;
         r_spawn_pend  <= 1'b0;
      end else begin
         r_spawn_valid <= 1'b0;
         r_fly_clear   <= 1'b0;
         r_sfx_hit     <= 1'b0;
         r_sfx_stage   <= 1'b0;
         r_sfx_over    <= 1'b0;
         if (i_frame_tick && (r_inv_cnt != 16'd0)) begin
            r_inv_cnt <= r_inv_cnt - 16'd1;
         end
         if (w_rst_stage) begin
            // Stage restart wins the whole cycle: no kills, hits or spawns are taken
            r_fly_clear  <= 1'b1;
            r_state      <= StIntro;
            r_frame_cnt  <= 16'd0;
            r_spawned    <= 5'd0;
            r_spawn_pend <= 1'b0;
         end else begin
            if (w_active && (i_fly_hit != '0)) begin
               r_score   <= w_score_next;
               r_sfx_hit <= 1'b1;
            end
            if (w_hit_ok) begin
               r_inv_cnt <= 16'(INVULN_FRAMES);
               r_lives   <= r_lives - 2'd1;
            end
            if (w_lose_game) begin
               // Losing the last life pre-empts any stage clear or spawn this cycle
               r_state     <= StOver;
               r_fly_clear <= 1'b1;
               r_sfx_over  <= 1'b1;
            end else begin
               unique case (r_state)
                  StIdle: begin
                     if (i_start) begin
                        r_state     <= StIntro;
                        r_frame_cnt <= 16'd0;
                     end
                  end
                  StIntro: begin
                     if (i_frame_tick) begin
                        if (r_frame_cnt == 16'(INTRO_FRAMES - 1)) begin
                           r_state      <= StSpawn;
                           r_frame_cnt  <= 16'd0;
                           r_spawned    <= 5'd0;
                           r_spawn_pend <= 1'b0;
                        end else begin
                           r_frame_cnt <= r_frame_cnt + 16'd1;
                        end
                     end
                  end
                  StSpawn: begin
                     if (i_frame_tick) begin
                        r_frame_cnt <= (r_frame_cnt == 16'(SPAWN_GAP - 1)) ? 16'd0
                                                                           : r_frame_cnt + 16'd1;
                     end
                     if (w_spawn_due) begin
                        if (w_free_any) begin
                           r_spawn_valid <= 1'b1;
                           r_spawn_idx   <= w_free_idx;
                           r_spawned     <= r_spawned + 5'd1;
                           r_spawn_pend  <= 1'b0;
                           if (r_spawned + 5'd1 == w_target) begin
                              r_state     <= StPlay;
                              r_frame_cnt <= 16'd0;
                           end
                        end else begin
                           r_spawn_pend <= 1'b1;
                        end
                     end
                  end
                  StPlay: begin
                     // Tick-qualified so a fresh spawn's alive bit has time to rise
                     if (i_frame_tick && (i_fly_alive == '0)) begin
                        r_state     <= StClear;
                        r_sfx_stage <= 1'b1;
                        r_frame_cnt <= 16'd0;
                     end
                  end
                  StClear: begin
                     if (i_frame_tick) begin
                        if (r_frame_cnt == 16'(CLEAR_FRAMES - 1)) begin
                           r_state     <= StIntro;
                           r_frame_cnt <= 16'd0;
                           r_stage     <= (r_stage == 4'd15) ? r_stage : r_stage + 4'd1;
                        end else begin
                           r_frame_cnt <= r_frame_cnt + 16'd1;
                        end
                     end
                  end
                  StOver: begin
                     if (i_start) begin
                        r_fly_clear <= 1'b1;
                        r_stage     <= 4'd1;
                        r_lives     <= 2'(LIVES_INIT);
                        r_score     <= 16'd0;
                        r_state     <= StIntro;
                        r_frame_cnt <= 16'd0;
                     end
                  end
                  default: r_state <= StIdle;
               endcase
            end
         end
      end
   end

   assign o_spawn_valid = r_spawn_valid;
   assign o_spawn_idx   = r_spawn_idx;
   assign o_fly_clear   = r_fly_clear;
   assign o_state       = r_state;
   assign o_stage       = r_stage;
   assign o_lives       = r_lives;
   assign o_score       = r_score;
   assign o_sfx_hit     = r_sfx_hit;
   assign o_sfx_stage   = r_sfx_stage;
   assign o_sfx_over    = r_sfx_over;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed vector table, hand-written corner sequences and a
// randomized phase, all shadowed cycle by cycle by a behavioural game model.
module tb_stage_sequencer;

   localparam int FC      = 12;
   localparam int BASE    = 4;
   localparam int GAP     = 30;
   localparam int INTRO   = 120;
   localparam int CLEARF  = 90;
   localparam int INVULN  = 60;
   localparam int LIVES0  = 3;
   localparam int PTS     = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          frame_tick = 1'b0;
   logic          start = 1'b0;
   logic          stage_rst = 1'b0;
   logic          player_hit = 1'b0;
   logic [FC-1:0] fly_alive = '0;
   logic [FC-1:0] fly_hit = '0;
   logic          spawn_valid;
   logic [3:0]    spawn_idx;
   logic          fly_clear;
   logic [2:0]    state;
   logic [3:0]    stage;
   logic [1:0]    lives;
   logic [15:0]   score;
   logic          sfx_hit, sfx_stage, sfx_over;

   int n_vec = 0;
   int n_bad = 0;

   stage_sequencer dut (
      .i_clk25      (clk),
      .i_reset      (reset),
      .i_frame_tick (frame_tick),
      .i_start      (start),
      .i_stage_rst  (stage_rst),
      .i_player_hit (player_hit),
      .i_fly_alive  (fly_alive),
      .i_fly_hit    (fly_hit),
      .o_spawn_valid(spawn_valid),
      .o_spawn_idx  (spawn_idx),
      .o_fly_clear  (fly_clear),
      .o_state      (state),
      .o_stage      (stage),
      .o_lives      (lives),
      .o_score      (score),
      .o_sfx_hit    (sfx_hit),
      .o_sfx_stage  (sfx_stage),
      .o_sfx_over   (sfx_over)
   );

   always #5 clk = ~clk;

   // Behavioural model: state numbers, countdowns of frames left, ticks to next spawn
   int m_state, m_stage, m_lives, m_score, m_wait, m_gap, m_spawned, m_inv, m_idx;
   bit m_pend, m_sv, m_clr, m_sh, m_ss, m_so;
   bit m_ok = 1'b0;

   task automatic model_step();
      bit active, hit_ok, found;
      int target, slot;
      m_sv = 0; m_clr = 0; m_sh = 0; m_ss = 0; m_so = 0;
      if (reset) begin
         m_state = 0; m_stage = 1; m_lives = LIVES0; m_score = 0; m_wait = 0; m_gap = 0;
         m_spawned = 0; m_inv = 0; m_idx = 0; m_pend = 0; m_ok = 1;
         return;
      end
      active = (m_state == 2) || (m_state == 3);
      hit_ok = active && player_hit && (m_inv == 0);
      if (frame_tick && m_inv > 0) m_inv--;
      if (stage_rst && m_state >= 1 && m_state <= 4) begin
         m_clr = 1; m_state = 1; m_wait = INTRO;
         return;
      end
      if (active && fly_hit != 0) begin
         m_score = m_score + $countones(fly_hit) * PTS;
         if (m_score > 65535) m_score = 65535;
         m_sh = 1;
      end
      if (hit_ok) begin
         m_lives--;
         m_inv = INVULN;
         if (m_lives == 0) begin
            m_state = 5; m_clr = 1; m_so = 1;
            return;
         end
      end
      case (m_state)
         0: if (start) begin m_state = 1; m_wait = INTRO; end
         1: if (frame_tick) begin
               m_wait--;
               if (m_wait == 0) begin m_state = 2; m_spawned = 0; m_pend = 0; m_gap = 0; end
            end
         2: begin
               found = 0; slot = 0;
               if (frame_tick) begin
                  if (m_gap == 0) begin m_pend = 1; m_gap = GAP - 1; end
                  else m_gap--;
               end
               if (m_pend) begin
                  for (int i = 0; i < FC; i++) begin
                     if (!fly_alive[i]) begin found = 1; slot = i; break; end
                  end
                  if (found) begin
                     m_sv = 1; m_idx = slot; m_spawned++; m_pend = 0;
                     target = BASE + m_stage - 1;
                     if (target > FC) target = FC;
                     if (m_spawned == target) m_state = 3;
                  end
               end
            end
         3: if (frame_tick && fly_alive == 0) begin m_state = 4; m_ss = 1; m_wait = CLEARF; end
         4: if (frame_tick) begin
               m_wait--;
               if (m_wait == 0) begin
                  m_state = 1; m_wait = INTRO;
                  if (m_stage < 15) m_stage++;
               end
            end
         5: if (start) begin
               m_clr = 1; m_stage = 1; m_lives = LIVES0; m_score = 0; m_state = 1;
               m_wait = INTRO;
            end
         default: ;
      endcase
   endtask

   task automatic chk(string name, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: model consumes the same inputs, outputs compared 1 time unit later
   task automatic step();
      logic [33:0] got, exp;
      @(posedge clk);
      model_step();
      #1;
      if (m_ok) begin
         got = {state, stage, lives, score, spawn_valid, spawn_idx,
                fly_clear, sfx_hit, sfx_stage, sfx_over};
         exp = {3'(m_state), 4'(m_stage), 2'(m_lives), 16'(m_score), m_sv, 4'(m_idx),
                m_clr, m_sh, m_ss, m_so};
         n_vec++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL model_cycle: got %h, expected %h (t=%0t)", got, exp, $time);
         end
      end
   endtask

   typedef struct {
      int          n;
      logic        rst, st_in, srst, phit, tick;
      logic [11:0] alive, hit;
      int          st, stg, lv, sc, sv, idx;
      logic [3:0]  pul; // {fly_clear, sfx_hit, sfx_stage, sfx_over}
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int n, logic rst, logic st_in, logic srst, logic phit,
                               logic tick, logic [11:0] alive, logic [11:0] hit, int st,
                               int stg, int lv, int sc, int sv, int idx, logic [3:0] pul);
      vec_t v;
      v.n = n; v.rst = rst; v.st_in = st_in; v.srst = srst; v.phit = phit; v.tick = tick;
      v.alive = alive; v.hit = hit; v.st = st; v.stg = stg; v.lv = lv; v.sc = sc;
      v.sv = sv; v.idx = idx; v.pul = pul;
      return v;
   endfunction

   initial begin
      int  sv_seen;
      bit  found;

      //              n  rst st sr ph tk alive    hit      st stg lv sc sv idx pulses
      tbl.push_back(mk(1,  1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 1, 3, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(1,  0, 1, 0, 0, 0, 12'h000, 12'h000, 1, 1, 3, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(119,0, 0, 0, 0, 1, 12'h000, 12'h000, 1, 1, 3, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(1,  0, 0, 0, 0, 1, 12'h000, 12'h000, 2, 1, 3, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(1,  0, 0, 0, 0, 1, 12'h000, 12'h000, 2, 1, 3, 0, 1, 0, 4'b0000));
      tbl.push_back(mk(1,  0, 0, 0, 0, 0, 12'h001, 12'h000, 2, 1, 3, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(29, 0, 0, 0, 0, 1, 12'h001, 12'h000, 2, 1, 3, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(1,  0, 0, 0, 0, 1, 12'h001, 12'h000, 2, 1, 3, 0, 1, 1, 4'b0000));
      tbl.push_back(mk(30, 0, 0, 0, 0, 1, 12'h003, 12'h000, 2, 1, 3, 0, 1, 2, 4'b0000));
      tbl.push_back(mk(30, 0, 0, 0, 0, 1, 12'h007, 12'h000, 3, 1, 3, 0, 1, 3, 4'b0000));
      tbl.push_back(mk(1,  0, 0, 0, 0, 0, 12'h00F, 12'h003, 3, 1, 3, 20, 0, 3, 4'b0100));
      tbl.push_back(mk(1,  0, 0, 0, 0, 0, 12'h00C, 12'h000, 3, 1, 3, 20, 0, 3, 4'b0000));
      tbl.push_back(mk(1,  0, 0, 0, 0, 0, 12'h00C, 12'h00C, 3, 1, 3, 40, 0, 3, 4'b0100));
      tbl.push_back(mk(1,  0, 0, 0, 0, 0, 12'h000, 12'h000, 3, 1, 3, 40, 0, 3, 4'b0000));
      tbl.push_back(mk(1,  0, 0, 0, 0, 1, 12'h000, 12'h000, 4, 1, 3, 40, 0, 3, 4'b0010));
      tbl.push_back(mk(89, 0, 0, 0, 0, 1, 12'h000, 12'h000, 4, 1, 3, 40, 0, 3, 4'b0000));
      tbl.push_back(mk(1,  0, 0, 0, 0, 1, 12'h000, 12'h000, 1, 2, 3, 40, 0, 3, 4'b0000));
      tbl.push_back(mk(120,0, 0, 0, 0, 1, 12'h000, 12'h000, 2, 2, 3, 40, 0, 3, 4'b0000));
      tbl.push_back(mk(1,  0, 0, 0, 0, 1, 12'h000, 12'h000, 2, 2, 3, 40, 1, 0, 4'b0000));
      tbl.push_back(mk(30, 0, 0, 0, 0, 1, 12'h000, 12'h000, 2, 2, 3, 40, 1, 0, 4'b0000));
      tbl.push_back(mk(30, 0, 0, 0, 0, 1, 12'h000, 12'h000, 2, 2, 3, 40, 1, 0, 4'b0000));
      tbl.push_back(mk(30, 0, 0, 0, 0, 1, 12'h000, 12'h000, 2, 2, 3, 40, 1, 0, 4'b0000));
      tbl.push_back(mk(30, 0, 0, 0, 0, 1, 12'h000, 12'h000, 3, 2, 3, 40, 1, 0, 4'b0000));
      tbl.push_back(mk(1,  0, 0, 0, 1, 0, 12'h001, 12'h000, 3, 2, 2, 40, 0, 0, 4'b0000));
      tbl.push_back(mk(59, 0, 0, 0, 1, 1, 12'h001, 12'h000, 3, 2, 2, 40, 0, 0, 4'b0000));
      tbl.push_back(mk(1,  0, 0, 0, 1, 1, 12'h001, 12'h000, 3, 2, 2, 40, 0, 0, 4'b0000));
      tbl.push_back(mk(1,  0, 0, 0, 1, 0, 12'h001, 12'h000, 3, 2, 1, 40, 0, 0, 4'b0000));
      tbl.push_back(mk(60, 0, 0, 0, 1, 1, 12'h001, 12'h000, 3, 2, 1, 40, 0, 0, 4'b0000));
      tbl.push_back(mk(1,  0, 0, 0, 1, 1, 12'h000, 12'h001, 5, 2, 0, 50, 0, 0, 4'b1101));
      tbl.push_back(mk(5,  0, 0, 0, 1, 1, 12'h000, 12'h000, 5, 2, 0, 50, 0, 0, 4'b0000));
      tbl.push_back(mk(1,  0, 1, 0, 0, 0, 12'h000, 12'h000, 1, 1, 3, 0, 0, 0, 4'b1000));
      tbl.push_back(mk(1,  0, 0, 0, 0, 0, 12'h000, 12'h000, 1, 1, 3, 0, 0, 0, 4'b0000));

      foreach (tbl[k]) begin
         reset = tbl[k].rst; start = tbl[k].st_in; stage_rst = tbl[k].srst;
         player_hit = tbl[k].phit; frame_tick = tbl[k].tick;
         fly_alive = tbl[k].alive; fly_hit = tbl[k].hit;
         repeat (tbl[k].n) step();
         chk($sformatf("tbl%0d_state", k), int'(state), tbl[k].st);
         chk($sformatf("tbl%0d_stage", k), int'(stage), tbl[k].stg);
         chk($sformatf("tbl%0d_lives", k), int'(lives), tbl[k].lv);
         chk($sformatf("tbl%0d_score", k), int'(score), tbl[k].sc);
         chk($sformatf("tbl%0d_spawn_valid", k), int'(spawn_valid), tbl[k].sv);
         chk($sformatf("tbl%0d_spawn_idx", k), int'(spawn_idx), tbl[k].idx);
         chk($sformatf("tbl%0d_pulses", k),
             int'({fly_clear, sfx_hit, sfx_stage, sfx_over}), int'(tbl[k].pul));
      end
      reset = 0; start = 0; stage_rst = 0; player_hit = 0; fly_hit = '0;

      // Run empty stages until stage 9 enters SPAWN (target 12)
      frame_tick = 1; fly_alive = '0; found = 0;
      for (int c = 0; c < 20000 && !found; c++) begin
         step();
         if (stage == 4'd9 && state == 3'd2) found = 1;
      end
      chk("reach_stage9_spawn", int'(found), 1);

      // Every slot occupied: spawn is deferred, then taken as soon as slot 7 frees
      fly_alive = 12'hFFF; sv_seen = 0;
      repeat (40) begin
         step();
         if (spawn_valid) sv_seen++;
      end
      chk("defer_no_spawn", sv_seen, 0);
      chk("defer_state", int'(state), 2);
      fly_alive = 12'hF7F; frame_tick = 0;
      step();
      chk("defer_release_valid", int'(spawn_valid), 1);
      chk("defer_release_idx", int'(spawn_idx), 7);

      // Stage restart keeps stage and score
      fly_alive = 12'hFFF; fly_hit = 12'h01F;
      step();
      fly_hit = '0;
      chk("pre_rst_score", int'(score), 50);
      stage_rst = 1;
      step();
      stage_rst = 0;
      chk("srst_clear", int'(fly_clear), 1);
      chk("srst_state", int'(state), 1);
      chk("srst_stage", int'(stage), 9);
      chk("srst_score", int'(score), 50);

      // Score saturation under sustained kills
      frame_tick = 1;
      repeat (120) step();
      chk("sat_state", int'(state), 2);
      frame_tick = 0; fly_hit = 12'hFFF;
      repeat (560) step();
      chk("sat_score", int'(score), 65535);
      chk("sat_sfx_hit", int'(sfx_hit), 1);
      fly_hit = '0;

      // Randomized play against the model
      reset = 1;
      step();
      for (int c = 0; c < 4000; c++) begin
         reset      = ($urandom_range(0, 499) == 0);
         start      = ($urandom_range(0, 7) == 0);
         stage_rst  = ($urandom_range(0, 127) == 0);
         player_hit = ($urandom_range(0, 7) == 0);
         frame_tick = 1'($urandom_range(0, 1));
         fly_alive  = ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom);
         fly_hit    = ($urandom_range(0, 5) == 0) ? 12'($urandom) : 12'h000;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
